seg_display_arbiter: RTL and testbench

Owns the shared 4-digit 7-segment display and the mode LEDs. Arbitrates among the four services (time set, alarm set, stopwatch, alarm check), each of which presents its own 16-bit BCD digit word. Grants exactly one owner, muxes that owner's digits onto the multiplexed `seg`/`anode` pins, and blinks the digit being edited. Sits between the service blocks and the board pins, replacing direct `num` drive from the services.

---
 rtl/seg_display_arbiter.sv | 160 ++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Display owner arbiter: grants one of four services the shared 4-digit 7-segment display,
// scans its BCD digits onto seg/anode and blinks the edited digit. Define SEG_DP_COLON_EN for an MM.SS colon.
module seg_display_arbiter #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic [15:0] num_s1,
  input  logic [15:0] num_s2,
  input  logic [15:0] num_s3,
  input  logic [15:0] num_s4,
  input  logic [3:0]  edit_sel,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [3:0]  spdt_led,
  output logic [7:0]  seg,
  output logic [3:0]  anode
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] RND_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, OWNED, LOCKED} state_t;

  state_t     state, state_next;
  logic [3:0] owner, owner_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 4'b0000;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_next = OWNED;
          casez (req)
            4'b1???: owner_next = 4'b1000;
            4'b01??: owner_next = 4'b0100;
            4'b001?: owner_next = 4'b0010;
            default: owner_next = 4'b0001;
          endcase
        end
      end
      OWNED: begin
        if ((done & owner) != 4'b0000)     state_next = LOCKED;
        else if ((req & owner) == 4'b0000) state_next = IDLE;
      end
      LOCKED: begin
        // owner still names the finished service; wait for its switch to drop
        if ((req & owner) == 4'b0000) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant    = (state == OWNED) ? owner : 4'b0000;
  assign busy     = (grant != 4'b0000);
  assign spdt_led = grant;

  logic [PW-1:0] pre;
  logic [1:0]    slot;
  logic [BW-1:0] rnd;
  logic          blink;
  logic          pre_wrap;
  logic          load;

  assign pre_wrap = (pre == PRE_LAST);
  assign load     = (pre == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre   <= '0;
      slot  <= 2'd0;
      rnd   <= '0;
      blink <= 1'b1;
    end else if (pre_wrap) begin
      pre  <= '0;
      slot <= slot + 2'd1;
      if (slot == 2'd3) begin
        if (rnd == RND_LAST) begin
          rnd   <= '0;
          blink <= ~blink;
        end else begin
          rnd <= rnd + 1'b1;
        end
      end
    end else begin
      pre <= pre + 1'b1;
    end
  end

  function automatic logic [6:0] to_7seg(input logic [3:0] v);
    case (v)
      4'd0:    to_7seg = 7'b0111111;
      4'd1:    to_7seg = 7'b0000110;
      4'd2:    to_7seg = 7'b1011011;
      4'd3:    to_7seg = 7'b1001111;
      4'd4:    to_7seg = 7'b1100110;
      4'd5:    to_7seg = 7'b1101101;
      4'd6:    to_7seg = 7'b1111101;
      4'd7:    to_7seg = 7'b0000111;
      4'd8:    to_7seg = 7'b1111111;
      4'd9:    to_7seg = 7'b1101111;
      default: to_7seg = 7'b0000000;
    endcase
  endfunction

  logic [15:0] cur_num;
  logic [3:0]  nibble;
  logic        digit_on;
  logic        dp;
  logic [7:0]  seg_d;
  logic [3:0]  anode_d;

  always_comb begin
    case (owner)
      4'b1000: cur_num = num_s1;
      4'b0100: cur_num = num_s2;
      4'b0010: cur_num = num_s3;
      default: cur_num = num_s4;
    endcase
    // slot 0 is the leftmost digit, so the nibble and edit bit index from the top
    nibble   = cur_num[{~slot, 2'b00} +: 4];
    digit_on = busy && !(edit_sel[~slot] && !blink);
`ifdef SEG_DP_COLON_EN
    dp = busy && (slot == 2'd1);
`else
    dp = 1'b0;
`endif
    seg_d   = {dp, digit_on ? to_7seg(nibble) : 7'b0000000};
    anode_d = ~(4'b1000 >> slot);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg   <= 8'h00;
      anode <= 4'b1111;
    end else if (load) begin
      seg   <= seg_d;
      anode <= anode_d;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-count based reference model.
module tb_seg_display_arbiter;

  localparam int SCAN  = 4;
  localparam int BLINK = 2;
`ifdef SEG_DP_COLON_EN
  localparam bit COLON = 1'b1;
`else
  localparam bit COLON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0, done = 4'b0, edit_sel = 4'b0;
  logic [15:0] num_s1 = 16'h0, num_s2 = 16'h0, num_s3 = 16'h0, num_s4 = 16'h0;
  logic [3:0]  grant, spdt_led, anode;
  logic        busy;
  logic [7:0]  seg;

  int n_cmp = 0;
  int n_bad = 0;

  seg_display_arbiter #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .num_s1(num_s1), .num_s2(num_s2), .num_s3(num_s3), .num_s4(num_s4),
    .edit_sel(edit_sel), .grant(grant), .busy(busy), .spdt_led(spdt_led),
    .seg(seg), .anode(anode)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: seg_of = 7'b0111111;  4'd1: seg_of = 7'b0000110;
      4'd2: seg_of = 7'b1011011;  4'd3: seg_of = 7'b1001111;
      4'd4: seg_of = 7'b1100110;  4'd5: seg_of = 7'b1101101;
      4'd6: seg_of = 7'b1111101;  4'd7: seg_of = 7'b0000111;
      4'd8: seg_of = 7'b1111111;  4'd9: seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  // Reference model: the scan position is derived from the clock count since reset release.
  typedef struct {
    int         cyc;
    int         mode;   // 0 idle, 1 owned, 2 locked
    logic [3:0] own;
    logic [3:0] grant;
    logic [7:0] seg;
    logic [3:0] anode;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_next(input mdl_t c, input logic [3:0] r, input logic [3:0] d,
                                      input logic [3:0] es, input logic [15:0] n1,
                                      input logic [15:0] n2, input logic [15:0] n3,
                                      input logic [15:0] n4);
    mdl_t        x;
    int          s;
    bit          vis;
    logic [15:0] nw;
    logic [3:0]  nib;
    logic [6:0]  dg;
    logic        dp;
    x = c;
    x.cyc = c.cyc + 1;
    if ((x.cyc - 1) % SCAN == 0) begin
      s   = ((x.cyc - 1) / SCAN) % 4;
      vis = ((((x.cyc - 1) / (SCAN * 4)) / BLINK) % 2) == 0;
      x.anode = 4'hF;
      x.anode[3 - s] = 1'b0;
      if (c.grant == 4'b0) begin
        x.seg = 8'h00;
      end else begin
        case (c.grant)
          4'b1000: nw = n1;
          4'b0100: nw = n2;
          4'b0010: nw = n3;
          default: nw = n4;
        endcase
        nib = nw[4 * (3 - s) +: 4];
        dg  = (nib > 4'd9) ? 7'd0 : seg_of(nib);
        if (es[3 - s] && !vis) dg = 7'd0;
        dp  = COLON && (s == 1);
        x.seg = {dp, dg};
      end
    end
    case (c.mode)
      0: if (r != 4'b0) begin
           x.own = 4'b0;
           for (int b = 3; b >= 0; b--) if (r[b] && x.own == 4'b0) x.own[b] = 1'b1;
           x.mode = 1;
         end
      1: if ((d & c.own) != 4'b0) x.mode = 2;
         else if ((r & c.own) == 4'b0) x.mode = 0;
      default: if ((r & c.own) == 4'b0) x.mode = 0;
    endcase
    x.grant = (x.mode == 1) ? x.own : 4'b0;
    return x;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m.cyc   <= 0;
      m.mode  <= 0;
      m.own   <= 4'b0;
      m.grant <= 4'b0;
      m.seg   <= 8'h00;
      m.anode <= 4'hF;
    end else begin
      m <= model_next(m, req, done, edit_sel, num_s1, num_s2, num_s3, num_s4);
    end
  end

  task automatic test_reset;
    logic [3:0] exp_an [4];
    exp_an = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (anode !== 4'hF) begin n_bad++; $display("FAIL reset_anode: got %b want 1111", anode); end
    if (seg !== 8'h00) begin n_bad++; $display("FAIL reset_seg: got %h want 00", seg); end
    if (grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (k == 0 ? 1 : SCAN) @(negedge clk);
      n_cmp++;
      if (anode !== exp_an[k]) begin
        n_bad++; $display("FAIL scan_anode_%0d: got %b want %b", k, anode, exp_an[k]);
      end
    end
  endtask

  task automatic test_grant_digits;
    logic [6:0] dig [4];
    int         s;
    logic [3:0] ea;
    dig = '{7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
    req = 4'b0; num_s2 = 16'h1234; edit_sel = 4'b0;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    n_cmp += 3;
    if (grant !== 4'b0100) begin n_bad++; $display("FAIL grant_s2: got %b want 0100", grant); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_s2: got %b want 1", busy); end
    if (spdt_led !== 4'b0100) begin n_bad++; $display("FAIL led_s2: got %b want 0100", spdt_led); end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4 * SCAN; i++) begin
      if ((m.cyc - 1) % SCAN == 0) begin
        s  = ((m.cyc - 1) / SCAN) % 4;
        ea = ~(4'b1000 >> s);
        n_cmp += 2;
        if (seg !== {COLON && s == 1, dig[s]}) begin
          n_bad++; $display("FAIL digit_slot%0d: got %b want %b", s, seg, {COLON && s == 1, dig[s]});
        end
        if (anode !== ea) begin n_bad++; $display("FAIL digit_anode%0d: got %b want %b", s, anode, ea); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_priority;
    req = 4'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0) begin n_bad++; $display("FAIL prio_idle: got %b want 0000", grant); end
    req = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b1000) begin n_bad++; $display("FAIL prio_all: got %b want 1000", grant); end
    req = 4'b0111;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0) begin n_bad++; $display("FAIL prio_release: got %b want 0000", grant); end
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0100) begin n_bad++; $display("FAIL prio_next: got %b want 0100", grant); end
  endtask

  task automatic test_done_lock;
    req = 4'b0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0010) begin n_bad++; $display("FAIL lock_grant: got %b want 0010", grant); end
    req = 4'b0011; done = 4'b1000;
    @(negedge clk);
    done = 4'b0;
    n_cmp++;
    if (grant !== 4'b0010) begin n_bad++; $display("FAIL lock_hold: got %b want 0010", grant); end
    done = 4'b0010;
    @(negedge clk);
    done = 4'b0;
    n_cmp++;
    if (grant !== 4'b0) begin n_bad++; $display("FAIL lock_done: got %b want 0000", grant); end
    repeat (6) @(negedge clk);
    n_cmp += 2;
    if (grant !== 4'b0) begin n_bad++; $display("FAIL lock_stay: got %b want 0000", grant); end
    if (seg !== 8'h00) begin n_bad++; $display("FAIL lock_blank: got %h want 00", seg); end
    req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0) begin n_bad++; $display("FAIL lock_exit: got %b want 0000", grant); end
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0001) begin n_bad++; $display("FAIL lock_regrant: got %b want 0001", grant); end
    req = 4'b0; done = 4'b0001;
    @(negedge clk);
    done = 4'b0;
    n_cmp++;
    if (grant !== 4'b0) begin n_bad++; $display("FAIL both_done: got %b want 0000", grant); end
    req = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0) begin n_bad++; $display("FAIL both_locked: got %b want 0000", grant); end
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0100) begin n_bad++; $display("FAIL both_after: got %b want 0100", grant); end
  endtask

  task automatic test_blink;
    int         s;
    bit         vis;
    logic [7:0] es;
    req = 4'b0;
    repeat (2) @(negedge clk);
    num_s1 = 16'h00A5; edit_sel = 4'b0001; req = 4'b1000;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 32 * SCAN; i++) begin
      if ((m.cyc - 1) % SCAN == 0) begin
        s   = ((m.cyc - 1) / SCAN) % 4;
        vis = ((((m.cyc - 1) / (SCAN * 4)) / BLINK) % 2) == 0;
        case (s)
          0:       es = {1'b0, seg_of(4'd0)};
          1:       es = {COLON, seg_of(4'd0)};
          2:       es = 8'h00;
          default: es = vis ? {1'b0, seg_of(4'd5)} : 8'h00;
        endcase
        n_cmp++;
        if (seg !== es) begin n_bad++; $display("FAIL blink_slot%0d: got %b want %b", s, seg, es); end
      end
      @(negedge clk);
    end
    edit_sel = 4'b0;
  endtask

  task automatic test_random;
    req = 4'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_cmp += 5;
      if (grant !== m.grant) begin n_bad++; $display("FAIL rnd_grant@%0d: got %b want %b", i, grant, m.grant); end
      if (busy !== (m.grant != 4'b0)) begin n_bad++; $display("FAIL rnd_busy@%0d: got %b", i, busy); end
      if (spdt_led !== m.grant) begin n_bad++; $display("FAIL rnd_led@%0d: got %b want %b", i, spdt_led, m.grant); end
      if (seg !== m.seg) begin n_bad++; $display("FAIL rnd_seg@%0d: got %b want %b", i, seg, m.seg); end
      if (anode !== m.anode) begin n_bad++; $display("FAIL rnd_anode@%0d: got %b want %b", i, anode, m.anode); end
      if ($urandom_range(7) == 0) req = 4'($urandom);
      done = ($urandom_range(9) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(3) == 0) begin
        num_s1 = 16'($urandom); num_s2 = 16'($urandom);
        num_s3 = 16'($urandom); num_s4 = 16'($urandom);
      end
      if ($urandom_range(15) == 0) edit_sel = (4'b0001 << $urandom_range(3)) & {4{$urandom_range(3) != 0}};
    end
    done = 4'b0;
  endtask

  task automatic test_async_reset;
    req = 4'b0;
    repeat (2) @(negedge clk);
    req = 4'b1000; num_s1 = 16'h8888;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp += 4;
    if (grant !== 4'b0) begin n_bad++; $display("FAIL arst_grant: got %b want 0000", grant); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    if (anode !== 4'hF) begin n_bad++; $display("FAIL arst_anode: got %b want 1111", anode); end
    if (seg !== 8'h00) begin n_bad++; $display("FAIL arst_seg: got %h want 00", seg); end
    @(negedge clk);
    req = 4'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_grant_digits;
    test_priority;
    test_done_lock;
    test_blink;
    test_random;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
